// File: rtl/sm_target_loader.sv
// Upstream stage of the SM feeder: assembles host stream records into the
// {ID, LENGTH, TARGET} feeder word, sanitises/masks the length, counts loads/drops.
module sm_target_loader #(
   parameter int TARGET_LENGTH = 128,
   parameter int LEN_WIDTH     = 12,
   parameter int ID_WIDTH      = 48,
   parameter int BUS_WIDTH     = 64,
   parameter int DATA_WORDS    = 2*TARGET_LENGTH/BUS_WIDTH,
   parameter int OUT_WIDTH     = ID_WIDTH+LEN_WIDTH+2*TARGET_LENGTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BUS_WIDTH-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 full,
   output logic [OUT_WIDTH-1:0] feed_out,
   output logic                 ld,
   output logic                 busy,
   output logic                 err_len,
   output logic [15:0]          rec_cnt,
   output logic [15:0]          drop_cnt
);
   localparam int TW   = 2*TARGET_LENGTH;
   localparam int WC_W = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;

   typedef enum logic [1:0] {HDR, DATA, PEND} state_t;

   state_t                state_q, state_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [TW-1:0]         tgt_q, tgt_d;
   logic [WC_W-1:0]       wcnt_q, wcnt_d;
   logic                  err_len_q, err_len_d;
   logic                  busy_q, busy_d;
   logic [15:0]           rec_cnt_q, rec_cnt_d;
   logic [15:0]           drop_cnt_q, drop_cnt_d;
   logic [TW-1:0]         msk;
   logic [LEN_WIDTH-1:0]  hdr_len;
   logic                  accept;

   // Mask applied as words are written, so the registered TARGET is already
   // clean when PEND is entered.
   for (genvar g = 0; g < TW; g++) begin : g_msk
      assign msk[g] = ({1'b0, len_q, 1'b0} > (LEN_WIDTH+2)'(g));
   end

   assign hdr_len  = in_data[LEN_WIDTH-1:0];
   assign in_ready = ~rst & (state_q != PEND);
   assign accept   = in_valid & in_ready;
   assign ld       = ~rst & (state_q == PEND) & ~full;
   assign feed_out = {id_q, len_q, tgt_q};
   assign busy     = busy_q;
   assign err_len  = err_len_q;
   assign rec_cnt  = rec_cnt_q;
   assign drop_cnt = drop_cnt_q;

   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      len_d      = len_q;
      tgt_d      = tgt_q;
      wcnt_d     = wcnt_q;
      err_len_d  = err_len_q;
      rec_cnt_d  = rec_cnt_q;
      drop_cnt_d = drop_cnt_q;
      case (state_q)
         HDR: if (accept) begin
            id_d   = in_data[BUS_WIDTH-1 -: ID_WIDTH];
            wcnt_d = '0;
            if (hdr_len > LEN_WIDTH'(TARGET_LENGTH)) begin
               len_d     = LEN_WIDTH'(TARGET_LENGTH);
               err_len_d = 1'b1;
            end else begin
               len_d = hdr_len;
            end
            state_d = DATA;
         end
         DATA: if (accept) begin
            tgt_d[int'(wcnt_q)*BUS_WIDTH +: BUS_WIDTH] =
               in_data & msk[int'(wcnt_q)*BUS_WIDTH +: BUS_WIDTH];
            wcnt_d = wcnt_q + WC_W'(1);
            if (wcnt_q == WC_W'(DATA_WORDS-1)) begin
               if (len_q != '0) begin
                  state_d = PEND;
               end else begin
                  drop_cnt_d = drop_cnt_q + 16'd1;
                  state_d    = HDR;
               end
            end
         end
         PEND: if (ld) begin
            rec_cnt_d = rec_cnt_q + 16'd1;
            state_d   = HDR;
         end
         default: state_d = HDR;
      endcase
      busy_d = (state_d != HDR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= HDR;
         id_q       <= '0;
         len_q      <= '0;
         tgt_q      <= '0;
         wcnt_q     <= '0;
         err_len_q  <= 1'b0;
         busy_q     <= 1'b0;
         rec_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         id_q       <= id_d;
         len_q      <= len_d;
         tgt_q      <= tgt_d;
         wcnt_q     <= wcnt_d;
         err_len_q  <= err_len_d;
         busy_q     <= busy_d;
         rec_cnt_q  <= rec_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end
endmodule
